// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and glyph constants for the seven-segment scan controller.
// All glyphs are active-low, bit 6 = segment a ... bit 0 = segment g.
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic [3:0] value;
    } digit_t;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

    // Power-up contents of both banks: dark digit showing 0.
    localparam digit_t DIGIT_RESET = '{blank: 1'b1, dp: 1'b0, value: 4'd0};

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side write/commit bus of the scan controller.
interface seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    localparam int AW = $clog2(NUM_DIGITS);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [5:0]    wr_data;
    logic          commit;
    logic          commit_pending;
    logic          commit_done;

    modport master (
        output wr_en, wr_addr, wr_data, commit,
        input  commit_pending, commit_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit,
        output commit_pending, commit_done
    );

endinterface

// File: rtl/seg_scan_ctrl_decode.sv
// 4-bit value to active-low seven-segment glyph.
// SEG_HEX_EN: when defined, 10..15 show A b C d E F; otherwise they are dark.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_OFF;
        case (value)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
`ifdef SEG_HEX_EN
            4'd10:   glyph = GLYPH_A;
            4'd11:   glyph = GLYPH_B;
            4'd12:   glyph = GLYPH_C;
            4'd13:   glyph = GLYPH_D;
            4'd14:   glyph = GLYPH_E;
            4'd15:   glyph = GLYPH_F;
`endif
            default: glyph = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a shadow bank that is
// committed to the displayed bank only when digit 0 starts, so frames never tear.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_CYCLES = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_scan_ctrl_if.slave        host,
    output logic                  frame_start,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int AW   = $clog2(NUM_DIGITS);
    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0]         DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [AW-1:0]         IDX_LAST   = AW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

    state_t        state;
    logic [AW-1:0] idx;
    logic [CW-1:0] cnt;
    digit_t        shadow [NUM_DIGITS];
    digit_t        active [NUM_DIGITS];

    digit_t        entry;
    logic [6:0]    glyph;
    logic          wr_ok;
    logic          copy_now;

    assign wr_ok = host.wr_en && (int'(host.wr_addr) < NUM_DIGITS);

    // The copy edge must already show the committed digit 0, so look through
    // to the shadow bank (pre-write value) when a commit is about to land.
    assign copy_now = (idx == '0) && host.commit_pending;
    assign entry    = copy_now ? shadow[idx] : active[idx];

    seg_decode u_decode (
        .value (entry.value),
        .glyph (glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= BLANK;
            idx                 <= '0;
            cnt                 <= '0;
            an                  <= '1;
            seg                 <= SEG_OFF;
            dp                  <= 1'b1;
            frame_start         <= 1'b0;
            host.commit_pending <= 1'b0;
            host.commit_done    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= DIGIT_RESET;
                active[i] <= DIGIT_RESET;
            end
        end else begin
            frame_start      <= 1'b0;
            host.commit_done <= 1'b0;

            if (host.commit)
                host.commit_pending <= 1'b1;
            if (wr_ok)
                shadow[host.wr_addr] <= digit_t'(host.wr_data);

            case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= DRIVE;
                        cnt   <= '0;
                        an    <= ~(AN_ONE << idx);
                        seg   <= entry.blank ? SEG_OFF : glyph;
                        dp    <= entry.blank | ~entry.dp;
                        if (idx == '0)
                            frame_start <= 1'b1;
                        if (copy_now) begin
                            active              <= shadow;
                            // a commit on the copy edge itself waits a frame
                            host.commit_pending <= host.commit;
                            host.commit_done    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt == DWELL_LAST) begin
                        state <= BLANK;
                        cnt   <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        an    <= '1;
                        seg   <= SEG_OFF;
                        dp    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a common-anode seven-segment display bank. Shares one cathode bus among NUM_DIGITS digits by sequencing the anodes with a ghost-suppression blanking gap between digits. A host writes per-digit values into a shadow bank, and the shadow bank is committed to the displayed bank only at a frame boundary, so the display never tears. It sits between the counter/application logic and the board's `an`/`seg`/`dp` pins.

## Interface
- `NUM_DIGITS`, 8: number of digits scanned (2..16).
- `DWELL_CYCLES`, 100000: clock cycles each digit is driven (≥1).
- `BLANK_CYCLES`, 2000: clock cycles all anodes are off before each digit (≥1).
- `clk` input 1: system clock.
- `rst_n` input 1: reset. Asynchronous assert, active-low.
- `wr_en` input 1: write strobe into the shadow bank.
- `wr_addr` input $clog2(NUM_DIGITS): digit index. Writes with an index ≥ NUM_DIGITS are ignored.
- `wr_data` input 6: [3:0] value, [4] dp on, [5] blank digit.
- `commit` input 1: request to copy shadow → active at the next frame start.
- `commit_pending` output 1: a commit is requested and not yet applied.
- `commit_done` output 1: one-cycle pulse on the cycle the copy occurs.
- `frame_start` output 1: one-cycle pulse when digit 0 begins DRIVE.
- `an` output NUM_DIGITS: anodes, active-low.
- `seg` output 7: cathodes, active-low. Bit 6 = a … bit 0 = g.
- `dp` output 1: decimal point, active-low.

## Operation
- FSM states: BLANK and DRIVE. Registers: `idx` (current digit) and `cnt` (cycle counter).
- In BLANK: `an` is all 1, `seg` = 7'b1111111, `dp` = 1. When `cnt` = BLANK_CYCLES−1, go to DRIVE and clear `cnt`.
- In DRIVE:
  - `an[idx]` = 0; all other anodes are 1.
  - `seg` is the decode of `active[idx]`. `dp` = ~`active[idx].dp`.
  - If `active[idx].blank` is set, `seg` = all 1 and `dp` = 1, while the anode still pulses.
  - When `cnt` = DWELL_CYCLES−1, go to BLANK, clear `cnt`, and advance `idx`. `idx` wraps from NUM_DIGITS−1 to 0.
- Decode, 0..9:
  - 0 → 0000001, 1 → 1001111, 2 → 0010010, 3 → 0000110, 4 → 1001100
  - 5 → 0100100, 6 → 0100000, 7 → 0001111, 8 → 0000000, 9 → 0000100
- Decode, 10..15: see Configuration.
- Write behaviour:
  - `wr_en` writes `shadow[wr_addr]` on the same edge. It is always accepted; there is no backpressure.
  - The last write to an address wins.
- Commit behaviour:
  - `commit` sets `commit_pending`. Further `commit` pulses while pending are merged into the one pending request.
  - On the BLANK → DRIVE edge for `idx` = 0, if pending: `active` ← `shadow`, pending is cleared, and `commit_done` pulses.
  - `commit` arriving on that same edge stays pending for the next frame.
  - A write on the copy edge lands in `shadow` only. `active` receives the pre-write value.

## Timing
- Reset values:
  - State = BLANK, `idx` = 0, `cnt` = 0.
  - `an` all 1, `seg` = 7'b1111111, `dp` = 1.
  - `commit_pending` = 0, `commit_done` = 0, `frame_start` = 0.
  - All shadow and active entries have blank = 1 and value = 0.
- `an`, `seg`, `dp` are registers that update on the same edge as the state register. There is no combinational path from inputs to pins.
- Digit period = BLANK_CYCLES + DWELL_CYCLES. Frame = NUM_DIGITS × digit period.
- First DRIVE of digit 0 begins BLANK_CYCLES cycles after `rst_n` deasserts. `frame_start` is high for that cycle.
- `commit` → `commit_done` latency is between 1 cycle and 1 frame.
- Reset asserted mid-frame: outputs blank immediately (asynchronous), and any pending commit is discarded.
- `cnt` is sized `$clog2(max(DWELL_CYCLES, BLANK_CYCLES))`, with a minimum of 1 bit.

## Configuration
- `SEG_HEX_EN` defined: values 10..15 decode as hex glyphs:
  - A → 0001000, b → 1100000, C → 0110001
  - d → 1000010, E → 0110000, F → 0111000
- `SEG_HEX_EN` undefined: values 10..15 decode to 7'b1111111 (dark). The anode timing is unchanged.

## Structure
- `seg_pkg` holds:
  - the state enum (BLANK, DRIVE);
  - the 7-bit glyph constants and the SEG_OFF constant;
  - the packed digit-entry struct {blank, dp, value[3:0]}.
- Sub-module `seg_decode`: combinational 4-bit value → 7-bit active-low glyph. The `SEG_HEX_EN` switch lives here only.

## Test plan
Parameters for all tests: NUM_DIGITS = 4, DWELL_CYCLES = 4, BLANK_CYCLES = 2.
- Reset release, no writes → `an` pattern 1111 for 2 cycles, then 1110 for 4 cycles; `seg` stays 1111111 throughout (all entries blank); `frame_start` pulses at cycle 2.
- Write 3, 7, 0, 9 to digits 0..3, then `commit` → `commit_done` coincides with the next `frame_start`. Then `seg` reads 0000110, 0001111, 0000001, 0000100 under `an` 1110, 1101, 1011, 0111. The pattern repeats every 24 cycles.
- Write digit 1 = {dp=1, value=5} without `commit` → display unchanged for 3 frames. `commit` then → `dp` = 0 and `seg` = 0100100 only while `an` = 1101.
- `commit` and a write of digit 0 = 8 on the copy edge → `active[0]` keeps its old value. The next `commit` shows 0000000.
- Write value 12 → with `SEG_HEX_EN`, `seg` = 0110001; without it, `seg` = 1111111.
- Assert `rst_n` = 0 mid-DRIVE with a commit pending → `an` = 1111 asynchronously; after release, `commit_pending` = 0 and all digits are dark.
